// File: rtl/pad_cond_pkg.sv
// Shared defaults for the switch-pad front-end: pad count, bit positions and timing.
package pad_cond_pkg;

  localparam int PAD_WIDTH_DEFAULT   = 3;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int DEBOUNCE_DEFAULT    = 4;

  localparam int X23_BIT = 0;
  localparam int X24_BIT = 1;
  localparam int X25_BIT = 2;

endpackage

// File: rtl/pad_debounce_bit.sv
// One pad bit: synchroniser chain, stability counter, debounced level and edge strobes.
module pad_debounce_bit
  import pad_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_upd,
  output logic o_level_nxt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_diff;
  logic                   w_upd;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_s != r_level);
  assign w_upd  = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Strobes are registered from the same condition that loads the level,
  // so they coincide exactly with the cycle the new level is visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      if (!w_diff || w_upd) r_cnt <= '0;
      else                  r_cnt <= r_cnt + CNT_W'(1);
      if (w_upd) r_level <= w_s;
      r_rise <= w_upd && w_s;
      r_fall <= w_upd && !w_s;
    end
  end

  assign o_level     = r_level;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_upd       = w_upd;
  assign o_level_nxt = w_upd ? w_s : r_level;

endmodule

// File: rtl/pad_input_conditioner.sv
// Switch-pad front-end: per-bit debounce plus a change-snapshot valid/ready channel with overrun flag.
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int WIDTH           = PAD_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             bertaClock,
  input  logic             global_reset_n,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             chg_valid,
  input  logic             chg_ready,
  output logic [WIDTH-1:0] chg_data,
  output logic             chg_overrun
);

  logic [WIDTH-1:0] w_upd;
  logic [WIDTH-1:0] w_level_nxt;
  logic             w_evt;
  logic             w_xfer;
  logic             r_chg_valid;
  logic [WIDTH-1:0] r_chg_data;
  logic             r_chg_overrun;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pad_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk      (bertaClock),
      .i_rst_n    (global_reset_n),
      .i_pad      (pad_in[g]),
      .o_level    (level_out[g]),
      .o_rise     (rise_pulse[g]),
      .o_fall     (fall_pulse[g]),
      .o_upd      (w_upd[g]),
      .o_level_nxt(w_level_nxt[g])
    );
  end

  assign w_evt  = |w_upd;
  assign w_xfer = r_chg_valid && chg_ready;

  always_ff @(posedge bertaClock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_chg_valid   <= 1'b0;
      r_chg_data    <= '0;
      r_chg_overrun <= 1'b0;
    end else begin
      if (w_evt) begin
        r_chg_data  <= w_level_nxt;
        r_chg_valid <= 1'b1;
      end else if (w_xfer) begin
        r_chg_valid <= 1'b0;
      end
      // Setting needs a pending, unaccepted snapshot, so it can never coincide with a transfer.
      if (w_evt && r_chg_valid && !chg_ready) r_chg_overrun <= 1'b1;
      else if (w_xfer)                        r_chg_overrun <= 1'b0;
    end
  end

  assign chg_valid   = r_chg_valid;
  assign chg_data    = r_chg_data;
  assign chg_overrun = r_chg_overrun;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner (WIDTH=3, 2 sync stages, 4-cycle debounce, 100ns clock).
module tb_pad_input_conditioner;

  logic       bertaClock = 1'b0;
  logic       global_reset_n = 1'b0;
  logic [2:0] pad_in = 3'b000;
  logic [2:0] level_out, rise_pulse, fall_pulse, chg_data;
  logic       chg_valid, chg_ready = 1'b0, chg_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  pad_input_conditioner #(
    .WIDTH          (3),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .bertaClock    (bertaClock),
    .global_reset_n(global_reset_n),
    .pad_in        (pad_in),
    .level_out     (level_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .chg_valid     (chg_valid),
    .chg_ready     (chg_ready),
    .chg_data      (chg_data),
    .chg_overrun   (chg_overrun)
  );

  always #50 bertaClock = ~bertaClock;

  // Observed vector: {level, rise, fall, valid, data, overrun}
  function automatic logic [13:0] obs();
    return {level_out, rise_pulse, fall_pulse, chg_valid, chg_data, chg_overrun};
  endfunction

  task automatic tick();
    @(posedge bertaClock);
    #1;
  endtask

  task automatic do_reset();
    global_reset_n = 1'b0;
    pad_in = 3'b000;
    chg_ready = 1'b0;
    tick();
    tick();
    global_reset_n = 1'b1;
    repeat (8) tick();
  endtask

  // Edge 0 below is always the first edge that captures the new pad level.
  task automatic test_reset();
    logic [13:0] exp;
    pad_in = 3'b111;
    chg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs() !== 14'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got %b exp %b", i, obs(), 14'b0);
      end
    end
    global_reset_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp = {(e >= 5) ? 3'b111 : 3'b000, (e == 5) ? 3'b111 : 3'b000, 3'b000,
             e >= 5, (e >= 5) ? 3'b111 : 3'b000, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_release e=%0d got %b exp %b", e, obs(), exp);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [13:0] exp;
    do_reset();
    chg_ready = 1'b1;
    pad_in = 3'b001;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp = {(e >= 5) ? 3'b001 : 3'b000, (e == 5) ? 3'b001 : 3'b000, 3'b000,
             e == 5, (e >= 5) ? 3'b001 : 3'b000, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL clean_rise e=%0d got %b exp %b", e, obs(), exp);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    chg_ready = 1'b1;
    pad_in = 3'b010;
    for (int e = 0; e <= 11; e++) begin
      tick();
      if (e == 2) pad_in = 3'b000;
      n_tests++;
      if (obs() !== 14'b0) begin
        n_fail++;
        $display("FAIL glitch e=%0d got %b exp %b", e, obs(), 14'b0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] exp;
    do_reset();
    chg_ready = 1'b0;
    pad_in = 3'b001;
    for (int e = 0; e <= 15; e++) begin
      tick();
      exp = {(e >= 5) ? 3'b001 : 3'b000, (e == 5) ? 3'b001 : 3'b000, 3'b000,
             e >= 5, (e >= 5) ? 3'b001 : 3'b000, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL backpressure e=%0d got %b exp %b", e, obs(), exp);
      end
    end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    n_tests++;
    if ({chg_valid, chg_overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL backpressure_accept got valid/ovr %b exp 00", {chg_valid, chg_overrun});
    end
  endtask

  task automatic test_overrun();
    logic [13:0] exp;
    do_reset();
    chg_ready = 1'b0;
    pad_in = 3'b001;
    for (int e = 0; e <= 14; e++) begin
      tick();
      if (e == 7) pad_in = 3'b011;
      if (e < 5)       exp = 14'b0;
      else if (e < 13) exp = {3'b001, (e == 5) ? 3'b001 : 3'b000, 3'b000, 1'b1, 3'b001, 1'b0};
      else             exp = {3'b011, (e == 13) ? 3'b010 : 3'b000, 3'b000, 1'b1, 3'b011, 1'b1};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL overrun e=%0d got %b exp %b", e, obs(), exp);
      end
    end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    n_tests++;
    if ({chg_valid, chg_overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL overrun_accept got valid/ovr %b exp 00", {chg_valid, chg_overrun});
    end
  endtask

  // Second change lands on the transfer edge, then both bits fall together.
  task automatic test_back_to_back();
    logic [13:0] exp;
    do_reset();
    chg_ready = 1'b1;
    pad_in = 3'b001;
    for (int e = 0; e <= 14; e++) begin
      tick();
      if (e == 0) pad_in = 3'b011;
      if (e == 7) pad_in = 3'b000;
      case (e)
        0, 1, 2, 3, 4:  exp = 14'b0;
        5:              exp = {3'b001, 3'b001, 3'b000, 1'b1, 3'b001, 1'b0};
        6:              exp = {3'b011, 3'b010, 3'b000, 1'b1, 3'b011, 1'b0};
        13:             exp = {3'b000, 3'b000, 3'b011, 1'b1, 3'b000, 1'b0};
        14:             exp = {3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0};
        default:        exp = {3'b011, 3'b000, 3'b000, 1'b0, 3'b011, 1'b0};
      endcase
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL back_to_back e=%0d got %b exp %b", e, obs(), exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp;
    do_reset();
    chg_ready = 1'b1;
    pad_in = 3'b100;
    for (int e = 0; e <= 3; e++) begin
      tick();
      n_tests++;
      if (obs() !== 14'b0) begin
        n_fail++;
        $display("FAIL reset_mid_count e=%0d got %b exp %b", e, obs(), 14'b0);
      end
    end
    global_reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs() !== 14'b0) begin
        n_fail++;
        $display("FAIL reset_mid_hold cyc=%0d got %b exp %b", i, obs(), 14'b0);
      end
      tick();
    end
    global_reset_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp = {(e >= 5) ? 3'b100 : 3'b000, (e == 5) ? 3'b100 : 3'b000, 3'b000,
             e == 5, (e >= 5) ? 3'b100 : 3'b000, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_release e=%0d got %b exp %b", e, obs(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
